// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor PWM drive stage.
// Holds the speed-to-duty conversion so both channels map speed identically.
package mtr_drv_pkg;

    localparam int PWM_BITS = 11;
    localparam logic [10:0] DUTY_OFS = 11'h400;

    typedef enum logic {DEAD, DRIVE} dt_state_t;

    // Offset-binary conversion: drop the LSB and re-centre zero speed at 50% duty.
    function automatic logic [10:0] spd2duty(input logic signed [11:0] spd);
        return spd[11:1] + DUTY_OFS;
    endfunction

endpackage

// File: rtl/pwm_dt.sv
// One PWM channel: raw comparator flop followed by a dead-time gate FSM that
// keeps the high-side and low-side gates from ever being on together.
module pwm_dt
    import mtr_drv_pkg::*;
#(
    parameter logic [5:0] DEAD_TIME = 6'd32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] duty_latched,
    input  logic                pwr_up,
    output logic                PWM1,
    output logic                PWM2
);

    logic      sig_q, sig_d;
    dt_state_t state_q, state_d;
    logic [5:0] dead_q, dead_d;

    // The toggle is detected against the value about to be registered, so the
    // dead window opens on the same edge the raw PWM changes.
    always_comb begin
        sig_d   = (cnt < duty_latched);
        state_d = state_q;
        dead_d  = dead_q;
        if (!pwr_up || (sig_d != sig_q)) begin
            state_d = DEAD;
            dead_d  = '0;
        end else if (state_q == DEAD) begin
            dead_d = dead_q + 6'd1;
            if (dead_d == DEAD_TIME) begin
                state_d = DRIVE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q   <= 1'b0;
            state_q <= DEAD;
            dead_q  <= '0;
        end else begin
            sig_q   <= sig_d;
            state_q <= state_d;
            dead_q  <= dead_d;
        end
    end

    // pwr_up gates combinationally so dropping it kills the gates at once.
    assign PWM1 = pwr_up && (state_q == DRIVE) && sig_q;
    assign PWM2 = pwr_up && (state_q == DRIVE) && !sig_q;

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM drive: shared period counter, period-aligned duty latches,
// period synch pulse, and two dead-time protected channels.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter logic [5:0] DEAD_TIME = 6'd32,
    parameter int         PWM_BITS  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               pwr_up,
    output logic               lft_PWM1,
    output logic               lft_PWM2,
    output logic               rght_PWM1,
    output logic               rght_PWM2,
    output logic               PWM_synch
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] lft_duty_q, lft_duty_d;
    logic [PWM_BITS-1:0] rght_duty_q, rght_duty_d;
    logic                synch_q, synch_d;

    // Duty only moves on the last count so a period is never cut mid-way.
    always_comb begin
        cnt_d       = cnt_q + PWM_BITS'(1);
        lft_duty_d  = lft_duty_q;
        rght_duty_d = rght_duty_q;
        synch_d     = (cnt_q == '0);
        if (cnt_q == '1) begin
            lft_duty_d  = spd2duty(lft_spd);
            rght_duty_d = spd2duty(rght_spd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            lft_duty_q  <= DUTY_OFS;
            rght_duty_q <= DUTY_OFS;
            synch_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lft_duty_q  <= lft_duty_d;
            rght_duty_q <= rght_duty_d;
            synch_q     <= synch_d;
        end
    end

    assign PWM_synch = synch_q;

    pwm_dt #(.DEAD_TIME(DEAD_TIME)) u_lft (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt_q),
        .duty_latched(lft_duty_q),
        .pwr_up      (pwr_up),
        .PWM1        (lft_PWM1),
        .PWM2        (lft_PWM2)
    );

    pwm_dt #(.DEAD_TIME(DEAD_TIME)) u_rght (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt_q),
        .duty_latched(rght_duty_q),
        .pwr_up      (pwr_up),
        .PWM1        (rght_PWM1),
        .PWM2        (rght_PWM2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv: a time-since-last-disturbance reference model
// feeds per-cycle expectations; a monitor compares and gathers per-period counts.
module tb_mtr_drv;

    localparam int DT  = 32;
    localparam int PER = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [11:0] lft_spd  = '0;
    logic signed [11:0] rght_spd = '0;
    logic pwr_up = 1'b1;
    logic lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch;

    mtr_drv #(.DEAD_TIME(6'd32), .PWM_BITS(11)) dut (
        .clk      (clk),
        .rst      (rst),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .pwr_up   (pwr_up),
        .lft_PWM1 (lft_PWM1),
        .lft_PWM2 (lft_PWM2),
        .rght_PWM1(rght_PWM1),
        .rght_PWM2(rght_PWM2),
        .PWM_synch(PWM_synch)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int lp1;
        int lp2;
        int rp1;
        int rp2;
        int len;
    } per_t;

    per_t       per_q[$];
    logic [4:0] sb_q[$];

    // Reference model state: duty per channel, last raw level, and the cycle
    // index of the last event (edge, power-down, reset) that restarts dead time.
    int k;
    int m_duty[2];
    bit m_sig[2];
    int m_last[2];

    logic signed [11:0] nxt_l   = '0;
    logic signed [11:0] nxt_r   = '0;
    logic               nxt_pwr = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [3:0] gates();
        return {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2};
    endfunction

    task automatic model_init();
        k = 0;
        for (int c = 0; c < 2; c++) begin
            m_duty[c] = 1024;
            m_sig[c]  = 1'b0;
            m_last[c] = 0;
        end
    endtask

    task automatic run(input int n);
        int sp[2];
        bit pw_prev;
        int cprev;
        bit sig;
        bit e1[2];
        bit e2[2];
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sp[0]   = int'(lft_spd);
            sp[1]   = int'(rght_spd);
            pw_prev = pwr_up;
            lft_spd  = nxt_l;
            rght_spd = nxt_r;
            pwr_up   = nxt_pwr;
            cprev = k % PER;
            k++;
            for (int c = 0; c < 2; c++) begin
                sig = (cprev < m_duty[c]);
                if (k % PER == 0) m_duty[c] = (sp[c] + 2048) / 2;
                if ((sig != m_sig[c]) || !pw_prev) m_last[c] = k;
                m_sig[c] = sig;
                e1[c] = pwr_up && sig && ((k - m_last[c]) >= DT);
                e2[c] = pwr_up && !sig && ((k - m_last[c]) >= DT);
            end
            sb_q.push_back({e1[0], e2[0], e1[1], e2[1], (k % PER) == 1});
            #1;
        end
    endtask

    task automatic run_to_cnt(input int c);
        for (int i = 0; i < PER + 1 && (k % PER) != c; i++) run(1);
    endtask

    task automatic check_period(input string nm, input int el1, input int el2,
                                input int er1, input int er2);
        per_t p;
        int b = 0;
        while (per_q.size() == 0 && b < 4500) begin
            run(1);
            b++;
        end
        if (per_q.size() == 0) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            p = per_q.pop_front();
            chk({nm, "_lft_pwm1"}, p.lp1, el1);
            chk({nm, "_lft_pwm2"}, p.lp2, el2);
            chk({nm, "_rght_pwm1"}, p.rp1, er1);
            chk({nm, "_rght_pwm2"}, p.rp2, er2);
            chk({nm, "_period"}, p.len, PER);
        end
    endtask

    // Monitor: per-cycle scoreboard pop, overlap tally, per-period gate counts.
    int    win_err = 0;
    int    win_ovl = 0;
    int    win_cyc = 0;
    string first_bad = "";
    bit    win_valid = 1'b0;
    per_t  cur;

    task automatic flush_win();
        chk($sformatf("sb_window %s", first_bad), win_err, 0);
        chk("no_gate_overlap", win_ovl, 0);
        win_err   = 0;
        win_ovl   = 0;
        win_cyc   = 0;
        first_bad = "";
    endtask

    initial begin
        logic [4:0] e;
        logic [4:0] a;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                win_valid = 1'b0;
            end else begin
                if (PWM_synch) begin
                    if (win_valid) per_q.push_back(cur);
                    cur = '{0, 0, 0, 0, 0};
                    win_valid = 1'b1;
                end
                cur.lp1 += int'(lft_PWM1);
                cur.lp2 += int'(lft_PWM2);
                cur.rp1 += int'(rght_PWM1);
                cur.rp2 += int'(rght_PWM2);
                cur.len++;
                if ((lft_PWM1 && lft_PWM2) || (rght_PWM1 && rght_PWM2)) win_ovl++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    a = {gates(), PWM_synch};
                    if (a !== e) begin
                        if (win_err == 0) first_bad = $sformatf("cycle %0d act=%b exp=%b", k, a, e);
                        win_err++;
                    end
                    win_cyc++;
                    if (win_cyc == 512) flush_win();
                end
            end
        end
    end

    initial begin
        int n;
        bit done;
        int total;
        int seg;

        // Reset state
        #22;
        chk("rst_lft_pwm1", int'(lft_PWM1), 0);
        chk("rst_lft_pwm2", int'(lft_PWM2), 0);
        chk("rst_rght_pwm1", int'(rght_PWM1), 0);
        chk("rst_rght_pwm2", int'(rght_PWM2), 0);
        chk("rst_synch", int'(PWM_synch), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_init();

        // Zero speed: 50% duty on both channels
        per_q.delete();
        check_period("zero", 992, 992, 992, 992);

        // Mid-period change only affects the following period
        run_to_cnt(500);
        nxt_l = 12'sh3FE;
        per_q.delete();
        check_period("mid_cur", 992, 992, 992, 992);
        check_period("mid_next", 1503, 481, 992, 992);

        // Extremes
        run_to_cnt(100);
        nxt_l = 12'sh7FF;
        nxt_r = 12'sh800;
        per_q.delete();
        check_period("ext_prev", 1503, 481, 992, 992);
        check_period("ext", 2015, 0, 0, 2048);

        // pwr_up drop and re-raise
        run_to_cnt(300);
        chk("pre_pwr_gates", int'(gates()), 4'b1001);
        nxt_pwr = 1'b0;
        run(1);
        chk("pwr_off_gates", int'(gates()), 0);
        run(40);
        nxt_pwr = 1'b1;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            run(1);
            if (gates() != 4'b0000) done = 1'b1;
            else n++;
        end
        chk("pwr_rise_dead", n, DT);

        // Asynchronous reset mid-period
        run_to_cnt(700);
        chk("pre_rst_gates", int'(gates()), 4'b1001);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", int'({gates(), PWM_synch}), 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        model_init();
        run(1);
        chk("synch_after_rst", int'(PWM_synch), 1);
        n = 0;
        done = 1'b0;
        if (gates() == 4'b0000) n++;
        else done = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            run(1);
            if (gates() != 4'b0000) done = 1'b1;
            else n++;
        end
        chk("rst_release_dead", n, DT);

        // Random speeds and power toggling
        total = 0;
        while (total < 15 * PER) begin
            seg = $urandom_range(50, 3000);
            case ($urandom_range(0, 5))
                0: nxt_l = 12'sh7FF;
                1: nxt_l = 12'sh800;
                2: nxt_l = 12'sh000;
                default: nxt_l = 12'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: nxt_r = 12'sh7FF;
                1: nxt_r = 12'sh800;
                2: nxt_r = 12'sh001;
                default: nxt_r = 12'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) nxt_pwr = !nxt_pwr;
            run(seg);
            total += seg;
        end
        nxt_pwr = 1'b1;
        run(1);

        @(negedge clk);
        #1;
        if (win_cyc > 0) flush_win();
        chk("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
